// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl: bit-serial, MSB-first unsigned magnitude compare of two
// WIDTH-bit operands with a valid/ready handshake on each side.
// Optional build macro: SERIAL_COMPARE_EARLY_EXIT_EN -- when defined, the scan
// stops on the first differing bit instead of always running WIDTH bits.

module magnitude_comparator (
  input  logic a,
  input  logic b,
  output logic a_gt,
  output logic a_eq,
  output logic a_lt
);
  assign a_gt = a & ~b;
  assign a_eq = ~(a ^ b);
  assign a_lt = ~a & b;
endmodule

module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_greater_b,
  output logic             a_equal_b,
  output logic             a_lower_b,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {R_EQ, R_GT, R_LT} res_t;

  state_t           state, state_nxt;
  res_t             res;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_p0, b_p0;
  logic             bit_gt, bit_eq, bit_lt;
  logic             accept, last_bit, early_exit;

  // Single 1-bit comparator, walked across the latched operands by idx
  magnitude_comparator u_cmp (
    .a    (a_p0[idx]),
    .b    (b_p0[idx]),
    .a_gt (bit_gt),
    .a_eq (bit_eq),
    .a_lt (bit_lt)
  );

  assign accept   = in_valid & in_ready;
  assign last_bit = (idx == '0);

`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
  // The first differing bit already decides the result; stop scanning there.
  assign early_exit = (res == R_EQ) & ~bit_eq;
`else
  assign early_exit = 1'b0;
`endif

  // State register; reset discards any job in flight
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and output decode; reset also masks in_ready combinationally
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    a_greater_b = 1'b0;
    a_equal_b   = 1'b0;
    a_lower_b   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (last_bit || early_exit) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        out_valid   = 1'b1;
        a_greater_b = (res == R_GT);
        a_equal_b   = (res == R_EQ);
        a_lower_b   = (res == R_LT);
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture on accept only; contents are don't-care until then
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0 <= a_in;
      b_p0 <= b_in;
    end
  end

  // Bit index and sticky result: first inequality wins, idx saturates at 0
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= IDX_MAX;
      res <= R_EQ;
    end else if (accept) begin
      idx <= IDX_MAX;
      res <= R_EQ;
    end else if (state == S_SHIFT) begin
      if (!last_bit) idx <= idx - 1'b1;
      if (res == R_EQ && !bit_eq) begin
        case ({bit_gt, bit_lt})
          2'b10:   res <= R_GT;
          2'b01:   res <= R_LT;
          default: res <= res;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Self-checking bench for serial_compare_ctrl: directed vectors, randomized
// jobs against a plain-arithmetic reference, back-pressure, reset and streaming.
module tb_serial_compare_ctrl;
  localparam int W = 8;
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic         a_greater_b, a_equal_b, a_lower_b, busy;
  logic [W-1:0] a_in, b_in;
  int           n_cmp = 0;
  int           n_bad = 0;

  serial_compare_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .a_greater_b(a_greater_b), .a_equal_b(a_equal_b), .a_lower_b(a_lower_b),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: flags from unsigned relations, latency from highest differing bit
  function automatic logic [2:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b);
    return {a > b, a == b, a < b};
  endfunction

  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    int hi = -1;
    for (int j = 0; j < W; j++) if (a[j] != b[j]) hi = j;
    return (EARLY && hi >= 0) ? W - hi : W;
  endfunction

  function automatic logic [2:0] flags();
    return {a_greater_b, a_equal_b, a_lower_b};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer one pair, then count edges until out_valid; noise drives ignored inputs
  task automatic do_job(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise,
                        output int lat, output logic [2:0] fl, output int bad);
    a_in = a; b_in = b; in_valid = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL accept_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    lat = 0; bad = 0;
    while (!out_valid && lat < 4 * W) begin
      if (in_ready !== 1'b0 || busy !== 1'b1 || flags() !== 3'b000) bad++;
      if (noise) begin
        in_valid = 1'($urandom);
        a_in = W'($urandom); b_in = W'($urandom);
      end
      tick();
      lat++;
    end
    fl = flags();
  endtask

  task automatic finish_job();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; a_in = 8'h12; b_in = 8'h34;
    tick();
    tick();
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_cmp++;
    if ({out_valid, busy, flags()} !== 5'b0) begin
      n_bad++; $display("FAIL reset_outputs got %b want 00000", {out_valid, busy, flags()});
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [W-1:0] va[4] = '{8'hA5, 8'h80, 8'h12, 8'h00};
    logic [W-1:0] vb[4] = '{8'hA5, 8'h7F, 8'h13, 8'hFF};
    int lat, bad;
    logic [2:0] fl;
    for (int i = 0; i < 4; i++) begin
      do_job(va[i], vb[i], 1'b0, lat, fl, bad);
      n_cmp++;
      if (lat !== ref_lat(va[i], vb[i])) begin
        n_bad++; $display("FAIL directed_latency a=%h b=%h got %0d want %0d", va[i], vb[i], lat, ref_lat(va[i], vb[i]));
      end
      n_cmp++;
      if (fl !== ref_flags(va[i], vb[i])) begin
        n_bad++; $display("FAIL directed_flags a=%h b=%h got %b want %b", va[i], vb[i], fl, ref_flags(va[i], vb[i]));
      end
      n_cmp++;
      if (bad !== 0) begin n_bad++; $display("FAIL directed_shift_outputs got %0d bad cycles want 0", bad); end
      finish_job();
      n_cmp++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
        n_bad++; $display("FAIL directed_after_handshake got %b want 010", {out_valid, in_ready, busy});
      end
    end
  endtask

  task automatic test_random();
    int lat, bad;
    logic [2:0] fl;
    logic [W-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 2))
        0:       b = a;
        1:       b = a ^ W'(1 << $urandom_range(0, W - 1));
        default: b = W'($urandom);
      endcase
      do_job(a, b, 1'b1, lat, fl, bad);
      n_cmp++;
      if (lat !== ref_lat(a, b) || fl !== ref_flags(a, b) || bad !== 0) begin
        n_bad++;
        $display("FAIL random_job a=%h b=%h got lat=%0d flags=%b bad=%0d want lat=%0d flags=%b bad=0",
                 a, b, lat, fl, bad, ref_lat(a, b), ref_flags(a, b));
      end
      repeat ($urandom_range(0, 2)) begin
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || fl !== flags()) begin
          n_bad++; $display("FAIL random_hold got ov=%b flags=%b want ov=1 flags=%b", out_valid, flags(), fl);
        end
      end
      finish_job();
    end
  endtask

  task automatic test_backpressure();
    int lat = 0;
    logic [2:0] first;
    a_in = 8'h90; b_in = 8'h30; in_valid = 1'b1;
    tick();
    a_in = 8'h01; b_in = 8'h02;
    while (!out_valid && lat < 4 * W) begin tick(); lat++; end
    n_cmp++;
    if (lat !== ref_lat(8'h90, 8'h30) || flags() !== ref_flags(8'h90, 8'h30)) begin
      n_bad++; $display("FAIL bp_first_job got lat=%0d flags=%b want lat=%0d flags=%b",
                        lat, flags(), ref_lat(8'h90, 8'h30), ref_flags(8'h90, 8'h30));
    end
    first = flags();
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || flags() !== first) begin
        n_bad++; $display("FAIL bp_hold cycle=%0d got rdy=%b ov=%b flags=%b want rdy=0 ov=1 flags=%b",
                          k, in_ready, out_valid, flags(), first);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_after_handshake got rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * W) begin tick(); lat++; end
    n_cmp++;
    if (lat !== ref_lat(8'h01, 8'h02) || flags() !== 3'b001) begin
      n_bad++; $display("FAIL bp_second_job got lat=%0d flags=%b want lat=%0d flags=001",
                        lat, flags(), ref_lat(8'h01, 8'h02));
    end
    finish_job();
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    int lat, bad;
    logic [2:0] fl;
    a_in = EARLY ? 8'h3C : 8'hF0;
    b_in = EARLY ? 8'h3C : 8'h0F;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, busy, flags()} !== 6'b010000) begin
      n_bad++; $display("FAIL reset_shift_outputs got %b want 010000", {out_valid, in_ready, busy, flags()});
    end
    repeat (12) begin tick(); seen |= out_valid; end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL reset_shift_no_result got %b want 0", seen); end
    do_job(8'h55, 8'h54, 1'b0, lat, fl, bad);
    n_cmp++;
    if (fl !== 3'b100) begin n_bad++; $display("FAIL reset_done_job got %b want 100", fl); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, busy, flags()} !== 6'b010000) begin
      n_bad++; $display("FAIL reset_done_outputs got %b want 010000", {out_valid, in_ready, busy, flags()});
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] pa[3], pb[3];
    logic [2:0] fl;
    bit rdy, ov;
    int cyc = 0, acc = 0, got = 0, hs_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      pa[i] = W'($urandom);
      pb[i] = (i == 1) ? pa[i] : W'($urandom);
    end
    a_in = pa[0]; b_in = pb[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (got < 3 && cyc < 200) begin
      rdy = in_ready; ov = out_valid; fl = flags();
      tick();
      cyc++;
      if (ov) begin
        n_cmp++;
        if (fl !== ref_flags(pa[got], pb[got])) begin
          n_bad++; $display("FAIL b2b_flags job=%0d got %b want %b", got, fl, ref_flags(pa[got], pb[got]));
        end
        hs_cyc = cyc;
        got++;
      end
      if (rdy && acc < 3) begin
        if (acc > 0) begin
          n_cmp++;
          if (cyc !== hs_cyc + 1) begin
            n_bad++; $display("FAIL b2b_accept_gap job=%0d got cycle %0d want %0d", acc, cyc, hs_cyc + 1);
          end
        end
        acc++;
        if (acc < 3) begin a_in = pa[acc]; b_in = pb[acc]; end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (got !== 3) begin n_bad++; $display("FAIL b2b_results got %0d want 3", got); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    tick();
    test_back_to_back();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
